// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: shift-mode encoding.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHR = 2'b00,
    MODE_SHL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle frame-complete pulse.
module shift_bit_counter #(
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Wrap explicitly at WIDTH-1 so non-power-of-2 widths never reach 2^CNT_W-1.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: SHR/SHL/ROR/ROL, parallel load, clear, shift counter.
// Optional registered parity output enabled by defining USHIFT_PARITY_EN.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     ser_in,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         q,
  output logic                     ser_out,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_done
`ifdef USHIFT_PARITY_EN
  ,
  output logic                     parity
`endif
);

  shift_mode_t      mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shr_v, shl_v;
  logic             shr_fill, shl_fill;
  logic             shift_acc;

  assign mode_s = shift_mode_t'(mode);

  // Rotates reuse the shift networks with the wrapped-around bit as the fill.
  assign shr_fill = (mode_s == MODE_ROR) ? q_q[0]       : ser_in;
  assign shl_fill = (mode_s == MODE_ROL) ? q_q[WIDTH-1] : ser_in;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_net
    if (gi == WIDTH - 1) begin : g_top
      assign shr_v[gi] = shr_fill;
    end else begin : g_mid_r
      assign shr_v[gi] = q_q[gi+1];
    end
    if (gi == 0) begin : g_bot
      assign shl_v[gi] = shl_fill;
    end else begin : g_mid_l
      assign shl_v[gi] = q_q[gi-1];
    end
  end

  assign shift_acc = en & ~clr & ~load;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RST_VAL;
    end else if (load) begin
      q_d = din;
    end else if (en) begin
      unique case (mode_s)
        MODE_SHR, MODE_ROR: q_d = shr_v;
        MODE_SHL, MODE_ROL: q_d = shl_v;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign ser_out = (mode_s == MODE_SHL || mode_s == MODE_ROL) ? q_q[WIDTH-1] : q_q[0];

  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr | load),
    .inc       (shift_acc),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

`ifdef USHIFT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= ^RST_VAL;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed 10-bit right-shift register.
- Adds shift-left, rotate-right, rotate-left, synchronous parallel load, synchronous clear, a serial output, and a shift counter with a frame-complete pulse.
- Sits between the debounced/one-shot pulse generator (drives `en`) and the LED/display or serial-link logic that consumes `q` / `ser_out`.

Parameters:
- WIDTH, 10: register width in bits; legal range 2..32.
- RST_VAL, 0: value loaded into `q` on `rst` and on `clr`; width WIDTH.
- Localparam CNT_W = $clog2(WIDTH): width of `bit_cnt`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; highest synchronous priority.
- load  in  1  synchronous parallel load of `din`.
- en  in  1  shift strobe, one clk wide, from the pulse generator.
- mode  in  2  operation: 00 SHR, 01 SHL, 10 ROR, 11 ROL.
- ser_in  in  1  serial input bit (used by SHR/SHL only).
- din  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit leaving on the next shift. Combinational: q[0] for modes 00/10, q[WIDTH-1] for modes 01/11.
- bit_cnt  out  CNT_W  number of shifts since the last load/clear/frame, modulo WIDTH.
- frame_done  out  1  registered one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset (async, rst=1): q=RST_VAL, bit_cnt=0, frame_done=0. Outputs are held while rst is high. Release is synchronous to the next edge with no glitch.
- Single always_ff for state; next-state computed combinationally, as in the existing block style.
- Synchronous priority per rising edge: clr > load > en > hold.
  - clr: q=RST_VAL, bit_cnt=0, frame_done=0.
  - load: q=din, bit_cnt=0, frame_done=0. `en` in the same cycle is ignored.
  - en with mode:
    - SHR: q={ser_in, q[WIDTH-1:1]}
    - SHL: q={q[WIDTH-2:0], ser_in}
    - ROR: q={q[0], q[WIDTH-1:1]}
    - ROL: q={q[WIDTH-2:0], q[WIDTH-1]}
  - no strobe: q, bit_cnt unchanged; frame_done=0.
- Counter: each accepted shift increments bit_cnt.
  - When bit_cnt==WIDTH-1 and a shift is accepted, bit_cnt wraps to 0 and frame_done=1 for exactly the next cycle.
  - Non-power-of-2 WIDTH must wrap at WIDTH-1, not at 2^CNT_W-1.
- `mode` is sampled only on an accepted `en` edge. A mode change mid-frame does not reset bit_cnt.
- `en` held high for N cycles yields N shifts; no edge detection inside the block.
- frame_done is never asserted two cycles in a row unless WIDTH shifts occur between pulses (impossible for WIDTH>=2).
- Latency: q, bit_cnt reflect an operation one edge after its strobe. ser_out follows q combinationally.

Optional Feature:
- Macro USHIFT_PARITY_EN.
- Defined: adds output port `parity` (1 bit, registered), the XOR of all bits of `q`'s next value, updated on the same edge as q. Reset/clear value is the XOR of RST_VAL.
- Undefined: port absent; no parity logic; all other behaviour identical.

Decomposition:
- Shared package `shift_pkg`: mode encoding constants MODE_SHR=2'b00, MODE_SHL=2'b01, MODE_ROR=2'b10, MODE_ROL=2'b11, and a typedef `shift_mode_t` (2-bit enum).
- One natural sub-module: `shift_bit_counter`.
  - Parameter WIDTH.
  - Inputs clk, rst, clr (clr|load), inc (accepted shift).
  - Outputs bit_cnt, frame_done.
  - Holds the modulo-WIDTH counter and done pulse.

Test Plan:
- Reset: WIDTH=10, RST_VAL=10'h2A5, pulse rst mid-shift -> q=10'h2A5, bit_cnt=0, frame_done=0 immediately (before next edge).
- SHR frame: load din=0; mode=00, ser_in=1, 10 en pulses -> q=10'h3FF; bit_cnt counts 1..9, then 0; frame_done high exactly one cycle after 10th pulse.
- Rotate: load 10'h001, mode=11, 3 en pulses -> q=10'h008; mode=10, 4 en pulses -> q=10'h200. ser_out=q[0] in mode 10, q[9] in mode 11.
- Priority: clr, load, en all high with din=10'h155 -> q=RST_VAL. Next cycle, load+en high -> q=10'h155, bit_cnt=0.
- Non-power-of-2 wrap: WIDTH=5, mode=01, 5 en pulses -> bit_cnt 1,2,3,4,0; frame_done after 5th pulse; 6th pulse -> bit_cnt=1, no frame_done.
- With USHIFT_PARITY_EN: load 10'h007 -> parity=1; SHL with ser_in=1 -> q=10'h00F, parity=0.
